clk_enable_gen: RTL and testbench

- Parametrised, all-digital successor to the fixed-ratio core clock generator.
- One fast fabric clock is turned into CHANNELS independent clock-enable strobes, each a fractional-N divider built on an NCO phase accumulator.
- Rates are reprogrammable at run time; a software "lock" sequence mimics PLL lock/relock and gates the strobes.
- Feeds CPU, video and audio clock-enable inputs of the arcade cores.

---
 rtl/clk_enable_gen.sv | 100 ++++++++++
 tb/tb_clk_enable_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// NCO-based fractional clock-enable generator with a software relock sequence.
// Optional macro CLKEN_GEN_ALIGN_EN adds an align input that zeroes all phase accumulators.
module clk_enable_gen #(
    parameter int                           CHANNELS    = 3,
    parameter int                           ACC_W       = 24,
    parameter int                           LOCK_CYCLES = 1024,
    parameter logic [CHANNELS*ACC_W-1:0]    INC_INIT    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_wr,
    input  logic [2:0]          inc_sel,
    input  logic [ACC_W-1:0]    inc_data,
`ifdef CLKEN_GEN_ALIGN_EN
    input  logic                align,
`endif
    output logic [CHANNELS-1:0] ce,
    output logic                lock,
    output logic                rst_out
);

    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic [ACC_W-1:0] acc [CHANNELS];
    logic [ACC_W-1:0] inc [CHANNELS];
    logic [ACC_W:0]   sum [CHANNELS];
    logic [CNT_W-1:0] lock_cnt;
    logic             inc_hit;
    logic             align_clr;
    logic             phase_clr;

    // inc_wr is a single-cycle strobe with no ready: a write with an in-range
    // inc_sel is always accepted on that edge and restarts the lock sequence.
    assign inc_hit = inc_wr && (int'(inc_sel) < CHANNELS);

`ifdef CLKEN_GEN_ALIGN_EN
    assign align_clr = align;
`else
    assign align_clr = 1'b0;
`endif

    assign phase_clr = inc_hit || !lock || align_clr;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    // lock is the whole relock state: low while counting, high once settled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock     <= 1'b0;
            lock_cnt <= '0;
        end else if (inc_hit) begin
            lock     <= 1'b0;
            lock_cnt <= '0;
        end else if (!lock) begin
            if (lock_cnt == CNT_LAST) begin
                lock <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_out <= 1'b1;
        end else begin
            rst_out <= ~lock;
        end
    end

    // Carry out of the accumulator is the strobe, registered one cycle late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (inc_hit && (inc_sel == 3'(i))) begin
                    inc[i] <= inc_data;
                end
                if (phase_clr) begin
                    acc[i] <= '0;
                    ce[i]  <= 1'b0;
                end else begin
                    acc[i] <= sum[i][ACC_W-1:0];
                    ce[i]  <= sum[i][ACC_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: directed test-plan sequence plus random writes/align/reset,
// checked each cycle against a closed-form pulse-count model of the NCO.
module tb_clk_enable_gen;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int LC = 16;
    localparam logic [CH*W-1:0] INIT = 24'h408000;

    logic          clk;
    logic          reset;
    logic          inc_wr;
    logic [2:0]    inc_sel;
    logic [W-1:0]  inc_data;
`ifdef CLKEN_GEN_ALIGN_EN
    logic          align;
`endif
    logic [CH-1:0] ce;
    logic          lock;
    logic          rst_out;

    clk_enable_gen #(
        .CHANNELS   (CH),
        .ACC_W      (W),
        .LOCK_CYCLES(LC),
        .INC_INIT   (INIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .inc_wr  (inc_wr),
        .inc_sel (inc_sel),
        .inc_data(inc_data),
`ifdef CLKEN_GEN_ALIGN_EN
        .align   (align),
`endif
        .ce      (ce),
        .lock    (lock),
        .rst_out (rst_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: lock after LC edges, pulses from floor(n*inc/2^W) differences
    int            m_inc [CH];
    int            m_step;
    int            m_elapsed;
    bit            m_lock;
    bit            m_rst_out;
    logic [CH-1:0] m_ce;
    logic [CH+1:0] exp_q [$];
    logic [CH*W-1:0] init_v;

    function automatic int pulses_upto(input int n, input int incv);
        return (n * incv) >> W;
    endfunction

    task automatic model_reset();
        init_v = INIT;
        for (int c = 0; c < CH; c++) m_inc[c] = int'(init_v[c*W +: W]);
        m_step    = 0;
        m_elapsed = 0;
        m_lock    = 1'b0;
        m_rst_out = 1'b1;
        m_ce      = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit wr, input int sel, input int data, input bit al);
        bit valid;
        bit nxt_rst;
        valid   = wr && (sel < CH);
        nxt_rst = !m_lock;
        if (m_lock && !valid && !al) begin
            for (int c = 0; c < CH; c++)
                m_ce[c] = (pulses_upto(m_step + 1, m_inc[c]) - pulses_upto(m_step, m_inc[c])) != 0;
            m_step = (m_step + 1) % (1 << W);
        end else begin
            m_ce   = '0;
            m_step = 0;
        end
        if (valid) begin
            m_lock    = 1'b0;
            m_elapsed = 0;
            m_inc[sel] = data & ((1 << W) - 1);
        end else if (!m_lock) begin
            m_elapsed++;
            if (m_elapsed == LC) m_lock = 1'b1;
        end
        m_rst_out = nxt_rst;
        exp_q.push_back({m_rst_out, m_lock, m_ce});
    endtask

    int pulse_cnt [CH];
    bit adjacent0;
    bit prev_ce0;

    // driver: one clock with the given inputs, then scoreboard compare at negedge
    task automatic cycle(input bit wr, input int sel, input int data, input bit al);
        logic [CH+1:0] e;
        bit al_eff;
        inc_wr   = wr;
        inc_sel  = sel[2:0];
        inc_data = data[W-1:0];
`ifdef CLKEN_GEN_ALIGN_EN
        align  = al;
        al_eff = al;
`else
        al_eff = 1'b0 & al;
`endif
        @(posedge clk);
        model_step(wr, sel, data, al_eff);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_value("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_value("ce", 32'(ce), 32'(e[CH-1:0]));
            check_value("lock", 32'(lock), 32'(e[CH]));
            check_value("rst_out", 32'(rst_out), 32'(e[CH+1]));
        end
        for (int c = 0; c < CH; c++) pulse_cnt[c] += int'(ce[c]);
        if (ce[0] && prev_ce0) adjacent0 = 1'b1;
        prev_ce0 = ce[0];
        inc_wr = 1'b0;
`ifdef CLKEN_GEN_ALIGN_EN
        align = 1'b0;
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic count_window(input int n);
        for (int c = 0; c < CH; c++) pulse_cnt[c] = 0;
        adjacent0 = 1'b0;
        prev_ce0  = 1'b0;
        idle(n);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_value("async_ce", 32'(ce), 32'(m_ce));
        check_value("async_lock", 32'(lock), 32'(m_lock));
        check_value("async_rst_out", 32'(rst_out), 32'(m_rst_out));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        inc_wr   = 1'b0;
        inc_sel  = '0;
        inc_data = '0;
`ifdef CLKEN_GEN_ALIGN_EN
        align    = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_value("reset_ce", 32'(ce), 32'd0);
        check_value("reset_lock", 32'(lock), 32'd0);
        check_value("reset_rst_out", 32'(rst_out), 32'd1);
        reset = 1'b0;

        // lock rises after LC clocks
        idle(LC - 1);
        check_value("lock_before_16", 32'(lock), 32'd0);
        idle(1);
        check_value("lock_at_16", 32'(lock), 32'd1);
        check_value("rst_out_at_16", 32'(rst_out), 32'd1);

        count_window(256);
        check_value("free_cnt0", 32'(pulse_cnt[0]), 32'd0);
        check_value("free_cnt1", 32'(pulse_cnt[1]), 32'd128);
        check_value("free_cnt2", 32'(pulse_cnt[2]), 32'd64);

        // reprogram ch0 to 0x55, relock, 85 pulses per 256
        cycle(1'b1, 0, 8'h55, 1'b0);
        check_value("relock_drop", 32'(lock), 32'd0);
        idle(LC);
        check_value("relock_back", 32'(lock), 32'd1);
        count_window(256);
        check_value("cnt0_55", 32'(pulse_cnt[0]), 32'd85);
        check_value("cnt0_adjacent", 32'(adjacent0), 32'd0);

        // out-of-range select changes nothing
        cycle(1'b1, 5, 8'h11, 1'b0);
        check_value("oor_lock", 32'(lock), 32'd1);
        count_window(256);
        check_value("oor_cnt0", 32'(pulse_cnt[0]), 32'd85);
        check_value("oor_cnt1", 32'(pulse_cnt[1]), 32'd128);
        check_value("oor_cnt2", 32'(pulse_cnt[2]), 32'd64);

        // reset mid-run restores INC_INIT
        cycle(1'b1, 0, 8'h20, 1'b0);
        idle(LC + 5);
        async_reset();
        idle(LC);
        count_window(256);
        check_value("post_reset_cnt0", 32'(pulse_cnt[0]), 32'd0);
        check_value("post_reset_cnt1", 32'(pulse_cnt[1]), 32'd128);

`ifdef CLKEN_GEN_ALIGN_EN
        cycle(1'b0, 0, 0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 0, 0, 1'b0);
            if (k % 4 == 0) check_value("align_together", 32'(ce[2:1]), 32'd3);
            else if (k % 2 == 0) check_value("align_ce1_only", 32'(ce[2:1]), 32'd1);
            else check_value("align_quiet", 32'(ce[2:1]), 32'd0);
        end
`endif

        // random writes, aligns and resets
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 4) cycle(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 1'b0);
            else if (r < 8) cycle(1'b0, 0, 0, 1'b1);
            else if (r == 199) async_reset();
            else cycle(1'b0, 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
